encoder_32_to_5: RTL and testbench

ENCODER_32_TO_5 -- requirements
Module: encoder_32_to_5

---
 rtl/encoder_32_to_5.sv | 74 +++++++
 tb/tb_encoder_32_to_5.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/encoder_32_to_5.sv
// rtl/encoder_32_to_5.sv - registered 32-to-5 priority encoder for register-file bus-drive requests
module encoder_32_to_5 (
    input  logic       R0out,
    input  logic       R1out,
    input  logic       R2out,
    input  logic       R3out,
    input  logic       R4out,
    input  logic       R5out,
    input  logic       R6out,
    input  logic       R7out,
    input  logic       R8out,
    input  logic       R9out,
    input  logic       R10out,
    input  logic       R11out,
    input  logic       R12out,
    input  logic       R13out,
    input  logic       R14out,
    input  logic       R15out,
    input  logic       HIout,
    input  logic       LOout,
    input  logic       Zhighout,
    input  logic       Zlowout,
    input  logic       PCout,
    input  logic       MDRout,
    input  logic       InPortout,
    input  logic       Cout,
    input  logic       in24,
    input  logic       in25,
    input  logic       in26,
    input  logic       in27,
    input  logic       in28,
    input  logic       in29,
    input  logic       in30,
    input  logic       in31,
    output logic [4:0] out,
    output logic       valid,
    input  logic       clk,
    input  logic       reset
);

    logic [31:0] req;
    logic [4:0]  win_code;
    logic        any_req;

    // Gather the individual request lines into one vector indexed by select code
    assign req = {in31, in30, in29, in28, in27, in26, in25, in24,
                  Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                  R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Lowest asserted index wins: scan downward so the smallest index is written last
    always_comb begin
        win_code = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                win_code = 5'(i);
            end
        end
    end

    assign any_req = |req;

    // Register the code and valid flag; reset clears both without waiting for clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out   <= 5'd0;
            valid <= 1'b0;
        end else begin
            out   <= win_code;
            valid <= any_req;
        end
    end

endmodule

// File: tb/tb_encoder_32_to_5.sv
// tb/tb_encoder_32_to_5.sv - directed self-checking bench for encoder_32_to_5
module tb_encoder_32_to_5;

    logic        clk;
    logic        reset;
    logic [31:0] req;
    logic [4:0]  out;
    logic        valid;

    int checks;
    int failures;

    encoder_32_to_5 dut (
        .R0out(req[0]),   .R1out(req[1]),   .R2out(req[2]),   .R3out(req[3]),
        .R4out(req[4]),   .R5out(req[5]),   .R6out(req[6]),   .R7out(req[7]),
        .R8out(req[8]),   .R9out(req[9]),   .R10out(req[10]), .R11out(req[11]),
        .R12out(req[12]), .R13out(req[13]), .R14out(req[14]), .R15out(req[15]),
        .HIout(req[16]),  .LOout(req[17]),  .Zhighout(req[18]), .Zlowout(req[19]),
        .PCout(req[20]),  .MDRout(req[21]), .InPortout(req[22]), .Cout(req[23]),
        .in24(req[24]),   .in25(req[25]),   .in26(req[26]),   .in27(req[27]),
        .in28(req[28]),   .in29(req[29]),   .in30(req[30]),   .in31(req[31]),
        .out(out),
        .valid(valid),
        .clk(clk),
        .reset(reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request vector at the falling edge, pass one rising edge, sample at the next falling edge
    task automatic apply(input logic [31:0] vec);
        req = vec;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        req      = 32'd0;

        // Asynchronous reset between edges with R7out active
        #2;
        req[7] = 1'b1;
        reset  = 1'b1;
        #1;
        check_eq("reset_out_async", 32'(out), 32'd0);
        check_eq("reset_valid_async", 32'(valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("reset_hold_out", 32'(out), 32'd0);
        check_eq("reset_hold_valid", 32'(valid), 32'd0);
        reset = 1'b0;

        // First edge after reset release samples normally
        apply(32'h0000_0080);
        check_eq("post_reset_out", 32'(out), 32'd7);
        check_eq("post_reset_valid", 32'(valid), 32'd1);

        // One-hot sweep R0out..in31
        for (int i = 0; i < 32; i++) begin
            apply(32'd1 << i);
            check_eq($sformatf("sweep_out_%0d", i), 32'(out), 32'(i));
            check_eq($sformatf("sweep_valid_%0d", i), 32'(valid), 32'd1);
        end

        // Mixed one-hot codes
        apply(32'h0000_0400);
        check_eq("r10_out", 32'(out), 32'd10);
        check_eq("r10_valid", 32'(valid), 32'd1);
        apply(32'h0001_0000);
        check_eq("hi_out", 32'(out), 32'd16);
        apply(32'h0080_0000);
        check_eq("c_out", 32'(out), 32'd23);

        // Priority: R3, R9, PC -> 3 ; HI, C -> 16 ; in24+in31 -> 24 ; everything -> 0
        apply(32'h0010_0208);
        check_eq("prio_r3_out", 32'(out), 32'd3);
        check_eq("prio_r3_valid", 32'(valid), 32'd1);
        apply(32'h0081_0000);
        check_eq("prio_hi_out", 32'(out), 32'd16);
        apply(32'h8100_0000);
        check_eq("prio_spare_out", 32'(out), 32'd24);
        apply(32'hFFFF_FFFF);
        check_eq("prio_all_out", 32'(out), 32'd0);
        check_eq("prio_all_valid", 32'(valid), 32'd1);

        // Idle
        apply(32'd0);
        check_eq("idle_out", 32'(out), 32'd0);
        check_eq("idle_valid", 32'(valid), 32'd0);

        // Latency: prior value 23, R5out rises just after an edge
        apply(32'h0080_0000);
        check_eq("lat_prior_out", 32'(out), 32'd23);
        @(posedge clk);
        #1;
        req = 32'h0000_0020;
        #2;
        check_eq("lat_hold_out", 32'(out), 32'd23);
        @(negedge clk);
        check_eq("lat_hold_out_neg", 32'(out), 32'd23);
        @(posedge clk);
        #1;
        check_eq("lat_new_out", 32'(out), 32'd5);
        check_eq("lat_new_valid", 32'(valid), 32'd1);

        // Glitch between edges has no effect
        @(negedge clk);
        req = 32'h0000_0002;
        #1;
        req = 32'h0000_0020;
        #1;
        check_eq("glitch_out", 32'(out), 32'd5);
        @(posedge clk);
        #1;
        check_eq("glitch_after_edge", 32'(out), 32'd5);

        // Mid-operation reset overrides pending request
        @(negedge clk);
        req   = 32'h0000_0080;
        reset = 1'b1;
        #1;
        check_eq("mid_reset_out", 32'(out), 32'd0);
        check_eq("mid_reset_valid", 32'(valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq("mid_reset_edge_out", 32'(out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply(32'h0000_0080);
        check_eq("mid_reset_release_out", 32'(out), 32'd7);
        check_eq("mid_reset_release_valid", 32'(valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
